// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, error codes, timing defaults and timer helper.
// Imported by the host-to-device transmitter and reusable by the receive path.
package ps2_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_WAIT_FIRST,
      ST_SEND,
      ST_WAIT_ACK,
      ST_WAIT_IDLE,
      ST_DONE,
      ST_FAIL
   } ps2_tx_state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_START_TO = 2'd1;
   localparam logic [1:0] ERR_FRAME_TO = 2'd2;
   localparam logic [1:0] ERR_NACK     = 2'd3;

   // Defaults assume a 50 MHz system clock.
   localparam int DEF_INHIBIT_CYCLES = 6000;
   localparam int DEF_START_TIMEOUT  = 750000;
   localparam int DEF_FRAME_TIMEOUT  = 100000;

   localparam int TIMER_W = 20;

   // Saturating increment so a stalled timer never wraps back below a limit.
   function automatic logic [TIMER_W-1:0] timer_sat_inc(input logic [TIMER_W-1:0] t);
      return (&t) ? t : t + TIMER_W'(1);
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser plus falling-edge detector for one raw PS/2 line.
// Flops reset to the idle-high level so leaving reset never produces a false edge.
module ps2_line_sync (
   input  logic clock,
   input  logic reset,
   input  logic line_raw,
   output logic line_level,
   output logic line_fall
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   always_ff @(posedge clock) begin
      if (!reset) begin
         meta_reg <= 1'b1;
         sync_reg <= 1'b1;
         prev_reg <= 1'b1;
      end else begin
         meta_reg <= line_raw;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign line_level = sync_reg;
   assign line_fall  = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, serialise start/data/parity/stop
// on device falling edges, then check the ACK. Lines are driven through open-drain enables.
module ps2_command_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
   parameter int unsigned FRAME_TIMEOUT  = DEF_FRAME_TIMEOUT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] in_byte,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] error_code
);

   localparam logic [TIMER_W-1:0] INHIBIT_LIM = TIMER_W'(INHIBIT_CYCLES);
   localparam logic [TIMER_W-1:0] START_LIM   = TIMER_W'(START_TIMEOUT);
   localparam logic [TIMER_W-1:0] FRAME_LIM   = TIMER_W'(FRAME_TIMEOUT);

   // Index 0 is PS2_CLK, index 1 is PS2_DAT.
   logic [1:0] line_raw;
   logic [1:0] line_level;
   logic [1:0] line_fall;
   logic       clk_level;
   logic       clk_fall;
   logic       dat_level;
   logic       unused_dat_fall;

   assign line_raw = {ps2_dat_in, ps2_clk_in};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         ps2_line_sync u_sync (
            .clock      (clock),
            .reset      (reset),
            .line_raw   (line_raw[gi]),
            .line_level (line_level[gi]),
            .line_fall  (line_fall[gi])
         );
      end
   endgenerate

   assign clk_level       = line_level[0];
   assign clk_fall        = line_fall[0];
   assign dat_level       = line_level[1];
   assign unused_dat_fall = line_fall[1];

   ps2_tx_state_t      state_reg, state_next;
   logic [TIMER_W-1:0] timer_reg, timer_next, timer_inc;
   logic [3:0]         bit_cnt_reg, bit_cnt_next;
   logic [7:0]         shift_reg, shift_next;
   logic               parity_reg, parity_next;
   logic               dat_oe_reg, dat_oe_next;
   logic [1:0]         error_code_reg, error_code_next;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         timer_reg      <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         parity_reg     <= 1'b0;
         dat_oe_reg     <= 1'b0;
         error_code_reg <= ERR_NONE;
      end else begin
         state_reg      <= state_next;
         timer_reg      <= timer_next;
         bit_cnt_reg    <= bit_cnt_next;
         shift_reg      <= shift_next;
         parity_reg     <= parity_next;
         dat_oe_reg     <= dat_oe_next;
         error_code_reg <= error_code_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      timer_next      = timer_reg;
      bit_cnt_next    = bit_cnt_reg;
      shift_next      = shift_reg;
      parity_next     = parity_reg;
      dat_oe_next     = dat_oe_reg;
      error_code_next = error_code_reg;
      timer_inc       = timer_sat_inc(timer_reg);

      case (state_reg)
         ST_IDLE: begin
            if (s_valid) begin
               shift_next      = in_byte;
               parity_next     = ~^in_byte;
               error_code_next = ERR_NONE;
               timer_next      = '0;
               state_next      = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (timer_inc >= INHIBIT_LIM) state_next = ST_REQ;
            else                          timer_next = timer_inc;
         end
         ST_REQ: begin
            // Start bit stays driven low while the clock line is handed to the device.
            timer_next   = '0;
            bit_cnt_next = '0;
            dat_oe_next  = 1'b1;
            state_next   = ST_WAIT_FIRST;
         end
         ST_WAIT_FIRST: begin
            if (clk_fall) begin
               bit_cnt_next = 4'd1;
               dat_oe_next  = ~shift_reg[0];
               shift_next   = {1'b0, shift_reg[7:1]};
               timer_next   = '0;
               state_next   = ST_SEND;
            end else if (timer_inc >= START_LIM) begin
               error_code_next = ERR_START_TO;
               state_next      = ST_FAIL;
            end else begin
               timer_next = timer_inc;
            end
         end
         ST_SEND: begin
            timer_next = timer_inc;
            if (clk_fall) begin
               bit_cnt_next = bit_cnt_reg + 4'd1;
               if (bit_cnt_reg <= 4'd7) begin
                  dat_oe_next = ~shift_reg[0];
                  shift_next  = {1'b0, shift_reg[7:1]};
               end else if (bit_cnt_reg == 4'd8) begin
                  dat_oe_next = ~parity_reg;
               end else begin
                  dat_oe_next = 1'b0;
                  state_next  = ST_WAIT_ACK;
               end
            end else if (timer_inc >= FRAME_LIM) begin
               error_code_next = ERR_FRAME_TO;
               state_next      = ST_FAIL;
            end
         end
         ST_WAIT_ACK: begin
            timer_next = timer_inc;
            if (clk_fall) begin
               if (!dat_level) begin
                  state_next = ST_WAIT_IDLE;
               end else begin
                  error_code_next = ERR_NACK;
                  state_next      = ST_FAIL;
               end
            end else if (timer_inc >= FRAME_LIM) begin
               error_code_next = ERR_FRAME_TO;
               state_next      = ST_FAIL;
            end
         end
         ST_WAIT_IDLE: begin
            timer_next = timer_inc;
            if (clk_level && dat_level) begin
               state_next = ST_DONE;
            end else if (timer_inc >= FRAME_LIM) begin
               error_code_next = ERR_FRAME_TO;
               state_next      = ST_FAIL;
            end
         end
         ST_DONE:  state_next = ST_IDLE;
         ST_FAIL:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase

      // The data enable only survives while a frame is actually on the wire.
      if (!(state_next inside {ST_WAIT_FIRST, ST_SEND, ST_WAIT_ACK})) dat_oe_next = 1'b0;
   end

   assign s_ready    = (state_reg == ST_IDLE);
   assign busy       = (state_reg != ST_IDLE);
   assign done       = (state_reg == ST_DONE);
   assign error      = (state_reg == ST_FAIL);
   assign error_code = error_code_reg;
   assign ps2_clk_oe = (state_reg == ST_INHIBIT) || (state_reg == ST_REQ);
   assign ps2_dat_oe = (state_reg == ST_REQ) || dat_oe_reg;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx with a cycle-timed PS/2 device model on open-drain lines.
module tb_ps2_command_tx;

   logic       clock;
   logic       reset;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] in_byte;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] error_code;
   logic       bfm_clk;
   logic       bfm_dat;
   logic       clk_line;
   logic       dat_line;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int done_cnt  = 0;
   int error_cnt = 0;

   assign clk_line = ~ps2_clk_oe & bfm_clk;
   assign dat_line = ~ps2_dat_oe & bfm_dat;

   ps2_command_tx #(
      .INHIBIT_CYCLES (10),
      .START_TIMEOUT  (200),
      .FRAME_TIMEOUT  (2000)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .in_byte    (in_byte),
      .ps2_clk_in (clk_line),
      .ps2_dat_in (dat_line),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .error_code (error_code)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (done)  done_cnt  <= done_cnt + 1;
      if (error) error_cnt <= error_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d", pass_cnt, check_cnt);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Hands one byte over, then counts cycles of clock-inhibit before the data line is pulled.
   task automatic send_byte(input logic [7:0] b, output int inhibit_n);
      @(posedge clock);
      #1 s_valid = 1'b1;
      in_byte = b;
      @(posedge clock);
      #1 s_valid = 1'b0;
      inhibit_n = 0;
      while (ps2_clk_oe && !ps2_dat_oe && inhibit_n < 100) begin
         wait_cyc(1);
         inhibit_n++;
      end
   endtask

   // Device model: waits for request-to-send, then clocks nedges falling edges (40-cycle period),
   // capturing the line on each rising edge and optionally driving ACK before edge 11.
   task automatic bfm_frame(input int nedges, input bit ack, output logic [9:0] cap);
      int n;
      cap = '0;
      n = 0;
      while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < 2000) begin
         wait_cyc(1);
         n++;
      end
      check("bfm_request_seen", 32'(n < 2000), 32'd1);
      wait_cyc(30);
      for (int i = 1; i <= nedges; i++) begin
         bfm_clk = 1'b0;
         wait_cyc(20);
         bfm_clk = 1'b1;
         if (i <= 10) cap[i-1] = dat_line;
         if (i == 10 && ack) begin
            wait_cyc(10);
            bfm_dat = 1'b0;
            wait_cyc(10);
         end else begin
            if (i == 11) bfm_dat = 1'b1;
            wait_cyc(20);
         end
      end
      bfm_dat = 1'b1;
   endtask

   logic [7:0]  good_bytes [3];
   logic        good_par   [3];
   logic [9:0]  cap;
   int          inh;
   int          n;
   int          d0;
   int          e0;
   string       tag;

   initial begin
      good_bytes[0] = 8'hED; good_par[0] = 1'b1;
      good_bytes[1] = 8'hF4; good_par[1] = 1'b0;
      good_bytes[2] = 8'h00; good_par[2] = 1'b1;

      reset   = 1'b0;
      s_valid = 1'b0;
      in_byte = 8'h00;
      bfm_clk = 1'b1;
      bfm_dat = 1'b1;
      wait_cyc(5);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      check("rst_done_error", 32'({done, error}), 32'd0);
      check("rst_error_code", 32'(error_code), 32'd0);
      reset = 1'b1;
      wait_cyc(3);

      // Good transfers.
      for (int t = 0; t < 3; t++) begin
         d0 = done_cnt;
         e0 = error_cnt;
         send_byte(good_bytes[t], inh);
         $display("tx 0x%02h: inhibit %0d cycles", good_bytes[t], inh);
         tag = $sformatf("inhibit_len_%02h", good_bytes[t]);
         check(tag, 32'(inh), 32'd10);
         bfm_frame(11, 1'b1, cap);
         $display("tx 0x%02h: captured data 0x%02h parity %0d stop %0d", good_bytes[t], cap[7:0], cap[8], cap[9]);
         check($sformatf("data_%02h", good_bytes[t]), 32'(cap[7:0]), 32'(good_bytes[t]));
         check($sformatf("parity_%02h", good_bytes[t]), 32'(cap[8]), 32'(good_par[t]));
         check($sformatf("stop_%02h", good_bytes[t]), 32'(cap[9]), 32'd1);
         check($sformatf("done_once_%02h", good_bytes[t]), 32'(done_cnt - d0), 32'd1);
         check($sformatf("no_error_%02h", good_bytes[t]), 32'(error_cnt - e0), 32'd0);
         check($sformatf("err_code_%02h", good_bytes[t]), 32'(error_code), 32'd0);
         check($sformatf("idle_after_%02h", good_bytes[t]), 32'(s_ready), 32'd1);
      end

      // Start timeout: device never clocks.
      e0 = error_cnt;
      send_byte(8'hF4, inh);
      n = 0;
      while (ps2_clk_oe && n < 100) begin
         wait_cyc(1);
         n++;
      end
      n = 0;
      while (!error && n < 1000) begin
         wait_cyc(1);
         n++;
      end
      $display("start timeout: error after %0d cycles, code %0d", n, error_code);
      check("start_to_cycles", 32'(n), 32'd200);
      check("start_to_code", 32'(error_code), 32'd1);
      check("start_to_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      wait_cyc(1);
      check("start_to_ready", 32'(s_ready), 32'd1);
      check("start_to_pulses", 32'(error_cnt - e0), 32'd1);

      // Frame timeout: device stops after four edges.
      e0 = error_cnt;
      send_byte(8'hED, inh);
      bfm_frame(4, 1'b1, cap);
      n = 0;
      while (!error && n < 3000) begin
         wait_cyc(1);
         n++;
      end
      $display("frame timeout: error after %0d more cycles, code %0d", n, error_code);
      check("frame_to_seen", 32'(n < 3000), 32'd1);
      check("frame_to_code", 32'(error_code), 32'd2);
      check("frame_to_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      wait_cyc(2);
      check("frame_to_pulses", 32'(error_cnt - e0), 32'd1);

      // No ACK: device leaves data high at the ACK edge.
      d0 = done_cnt;
      e0 = error_cnt;
      send_byte(8'hFF, inh);
      bfm_frame(11, 1'b0, cap);
      $display("nack: error pulses %0d done pulses %0d code %0d", error_cnt - e0, done_cnt - d0, error_code);
      check("nack_error", 32'(error_cnt - e0), 32'd1);
      check("nack_code", 32'(error_code), 32'd3);
      check("nack_no_done", 32'(done_cnt - d0), 32'd0);

      // Reset mid-frame at bit 5, with a stray s_valid during SEND.
      send_byte(8'hED, inh);
      bfm_frame(6, 1'b1, cap);
      s_valid = 1'b1;
      in_byte = 8'h55;
      wait_cyc(1);
      s_valid = 1'b0;
      check("midframe_busy", 32'(busy), 32'd1);
      check("midframe_not_accepted", 32'(ps2_clk_oe), 32'd0);
      reset = 1'b0;
      wait_cyc(1);
      $display("mid-frame reset: busy %0d clk_oe %0d dat_oe %0d", busy, ps2_clk_oe, ps2_dat_oe);
      check("midrst_idle", 32'(busy), 32'd0);
      check("midrst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      reset = 1'b1;
      wait_cyc(3);

      d0 = done_cnt;
      e0 = error_cnt;
      send_byte(8'hFF, inh);
      bfm_frame(11, 1'b1, cap);
      $display("tx 0xff after reset: captured data 0x%02h parity %0d stop %0d", cap[7:0], cap[8], cap[9]);
      check("post_rst_data", 32'(cap[7:0]), 32'hFF);
      check("post_rst_parity", 32'(cap[8]), 32'd1);
      check("post_rst_done", 32'(done_cnt - d0), 32'd1);
      check("post_rst_no_error", 32'(error_cnt - e0), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/ps2_command_tx.md
Name: ps2_command_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It is the write-direction counterpart of the keyboard receive path.
- Accepts a byte over a valid/ready handshake from game control logic.
- Performs the PS/2 request-to-send sequence, then serialises start, data, odd parity and stop bits on device-generated clock edges.
- Checks the device ACK and reports done or error.
- Drives PS2_CLK/PS2_DAT through open-drain enables. The top level ties each line as: line = oe ? 0 : Z.

Parameters:
INHIBIT_CYCLES, 6000, cycles clk is held low before the request (120 us at 50 MHz)
START_TIMEOUT, 750000, max cycles from clk release to the first device falling edge (15 ms)
FRAME_TIMEOUT, 100000, max cycles from the first falling edge to the ACK sample (2 ms)

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-low reset
s_valid  in  1  command byte valid
s_ready  out  1  high only in IDLE; transfer occurs when s_valid & s_ready
in_byte  in  8  command byte, latched on transfer
ps2_clk_in  in  1  raw PS2_CLK line level (asynchronous)
ps2_dat_in  in  1  raw PS2_DAT line level (asynchronous)
ps2_clk_oe  out  1  1 = pull PS2_CLK low
ps2_dat_oe  out  1  1 = pull PS2_DAT low
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: byte acknowledged and lines idle
error  out  1  one-cycle pulse on failure
error_code  out  2  0 none, 1 start timeout, 2 frame timeout, 3 no ACK; held until the next transfer

Behaviour:
Interface: reset is synchronous, active-low; the clock is clock.

Reset:
- state=IDLE; ps2_clk_oe=0, ps2_dat_oe=0; done=0, error=0, error_code=0; s_ready=1.
- Applies on the cycle after reset is sampled low, including mid-frame; both lines are released immediately.

Input sampling:
- Both lines pass through a 2-flop synchroniser.
- fall = prev & ~cur on the synchronised clk.
- Only falling edges are acted on. Rising edges, including the one produced by our own clk release, are ignored.

Transfer:
- On s_valid & s_ready: latch shift = in_byte and parity = ~^in_byte (odd parity).
- Clear error_code; enter INHIBIT.

States:
- IDLE: both oe=0; s_ready=1.
- INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles → REQ.
- REQ: clk_oe=1, dat_oe=1 (start bit = 0) for 1 cycle. Then clk_oe=0 with dat_oe held at 1; clear timer and bit_cnt=0 → WAIT_FIRST.
- WAIT_FIRST: on fall, bit_cnt=1 and dat_oe=~shift[0] (shift right) → SEND; restart timer. If the timer reaches START_TIMEOUT: error code 1 → FAIL.
- SEND, on each fall with bit_cnt k:
  - k=1..7: dat_oe=~data bit k.
  - k=8: dat_oe=~parity.
  - k=9: dat_oe=0 (stop bit = 1, line released).
  - bit_cnt increments on each fall; after the fall at k=9 → WAIT_ACK.
- WAIT_ACK: on fall, sample synchronised dat. If 0 → WAIT_IDLE; if 1, error code 3 → FAIL.
- WAIT_IDLE: when synchronised clk=1 and dat=1 → DONE.
- FRAME_TIMEOUT: counted from entry to SEND through WAIT_IDLE. On expiry, error code 2 → FAIL.
- DONE: done=1 for one cycle → IDLE.
- FAIL: error=1 for one cycle, both oe=0 → IDLE.

Other rules:
- s_valid is ignored while busy; the held in_byte does not affect the byte in flight.
- Timer width is 20 bits; compare is ≥ and the timer saturates (no wrap).
- bit_cnt is 4 bits.

Decomposition:
- Package ps2_pkg: state enum, error-code localparams (ERR_NONE, ERR_START_TO, ERR_FRAME_TO, ERR_NACK), and default timing constants.
- Sub-module ps2_line_sync: 2-flop synchroniser plus falling-edge detector for one line. It is instantiated twice here and is reusable by the keyboard receive path.

Test Plan:
Bench uses INHIBIT_CYCLES=10, START_TIMEOUT=200, FRAME_TIMEOUT=2000, with a device BFM clocking at a 40-cycle period.
- 0xED sent, BFM ACKs → BFM captures data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; error_code=0; clk_oe held low for exactly 10 cycles before dat_oe rises.
- 0xF4 sent → parity 0; 0x00 sent → parity 1; both end with done.
- BFM never clocks → error pulses with error_code=1 exactly 200 cycles after clk release; both oe=0; s_ready=1 the next cycle.
- BFM stops clocking after 4 edges → error with error_code=2; lines released.
- BFM leaves dat high at the ACK edge → error with error_code=3; no done pulse.
- Reset asserted at bit 5, and s_valid pulsed during SEND → oe=0 and state=IDLE one cycle after reset; the mid-frame s_valid is not accepted. A new 0xFF after reset completes with done.
